// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner:
//   - state_t   : per-channel debounce FSM state encoding (2 bits)
//   - cnt_width : width of the per-channel counter, sized so that the largest
//                 of the debounce / hold / repeat intervals fits
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    function automatic int cnt_width(input int debounce, input int hold, input int rep);
        int m;
        m = debounce;
        if (hold > m) m = hold;
        if (rep > m) m = rep;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button channel: 2-flop synchroniser, counter-based debounce FSM,
// registered single-cycle press/release pulses and optional hold-to-repeat.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-low
//   btn_in        in   raw asynchronous button input
//   repeat_en     in   auto-repeat enable, sampled every cycle
//   press_pulse   out  1-cycle pulse on accepted press and on each repeat
//   release_pulse out  1-cycle pulse on accepted release
//   btn_level     out  debounced pressed level (1 = pressed)
// -----------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic press_pulse,
    output logic release_pulse,
    output logic btn_level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    // Level the raw input shows when the button is not pressed.
    localparam logic REL_LEVEL = (ACTIVE_LOW != 0);

    logic          sync_a;
    logic          sync_b;
    logic          pressed;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    // 0 = waiting out the initial hold delay, 1 = in the repeat cadence.
    logic          rep_phase;
    logic          rep_phase_next;
    logic          press_next;
    logic          release_next;

    assign pressed   = sync_b ^ REL_LEVEL;
    assign btn_level = (state == HELD) || (state == DB_REL);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as the hardware does.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Synchroniser starts at the released level so leaving reset never
            // looks like a press edge.
            sync_a        <= REL_LEVEL;
            sync_b        <= REL_LEVEL;
            state         <= IDLE;
            cnt           <= '0;
            rep_phase     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_a        <= btn_in;
            sync_b        <= sync_a;
            state         <= state_next;
            cnt           <= cnt_next;
            rep_phase     <= rep_phase_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rep_phase_next = rep_phase;
        press_next     = 1'b0;
        release_next   = 1'b0;

        case (state)
            IDLE: begin
                if (pressed) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end

            DB_PRESS: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next     = HELD;
                    cnt_next       = '0;
                    rep_phase_next = 1'b0;
                    press_next     = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            HELD: begin
                if (!pressed) begin
                    state_next = DB_REL;
                    cnt_next   = '0;
                end else if (!repeat_en) begin
                    // Parked timer: re-enabling starts over with the hold delay.
                    cnt_next       = '0;
                    rep_phase_next = 1'b0;
                end else if (cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
                    cnt_next       = '0;
                    rep_phase_next = 1'b1;
                    press_next     = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            DB_REL: begin
                if (pressed) begin
                    // Release bounce: back to held, repeat timer from the top.
                    state_next     = HELD;
                    cnt_next       = '0;
                    rep_phase_next = 1'b0;
                end else if (cnt == DB_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Multi-channel button conditioner: CHANNELS independent button_channel
// instances, each synchronising, debouncing and shaping one push-button.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-low
//   btn_in        in   [CHANNELS] raw asynchronous button inputs
//   repeat_en     in   [CHANNELS] per-channel auto-repeat enable
//   press_pulse   out  [CHANNELS] 1-cycle pulse on accepted press / repeat
//   release_pulse out  [CHANNELS] 1-cycle pulse on accepted release
//   btn_level     out  [CHANNELS] debounced pressed level (1 = pressed)
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] btn_level
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .btn_in       (btn_in[i]),
            .repeat_en    (repeat_en[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .btn_level    (btn_level[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=5, active-low buttons. Inputs change 1 ns
// after a rising edge; "tick j" of a window is the j-th rising edge after the
// inputs were set, and outputs are sampled 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] repeat_en;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] btn_level;

    int total = 0;
    int bad   = 0;

    // Per-window observations filled in by watch().
    int np[CH];
    int nr[CH];
    int fp[CH];
    int fr[CH];
    int both;
    int pt[16];
    int pt_n;

    button_conditioner #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (5),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .btn_level    (btn_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n ticks, recording pulse counts, first-pulse tick per channel and
    // the press-pulse ticks of channel tch.
    task automatic watch(input int n, input int tch);
        for (int c = 0; c < CH; c++) begin
            np[c] = 0; nr[c] = 0; fp[c] = 0; fr[c] = 0;
        end
        both = 0;
        pt_n = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            for (int c = 0; c < CH; c++) begin
                if (press_pulse[c]) begin
                    np[c]++;
                    if (fp[c] == 0) fp[c] = j;
                    if (c == tch && pt_n < 16) begin
                        pt[pt_n] = j;
                        pt_n++;
                    end
                end
                if (release_pulse[c]) begin
                    nr[c]++;
                    if (fr[c] == 0) fr[c] = j;
                end
                if (press_pulse[c] && release_pulse[c]) both++;
            end
        end
    endtask

    initial begin
        int exp_rep[7];
        int np_acc;
        int nr_acc;
        exp_rep = '{7, 17, 22, 27, 32, 37, 42};

        // ---------------- reset ----------------
        rst       = 1'b0;
        btn_in    = '1;
        repeat_en = '0;
        step(); step(); step();
        check("reset_press", int'(press_pulse), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_level", int'(btn_level), 0);
        rst = 1'b1;
        watch(5, 0);
        check("idle_no_press", np[0] + np[1] + np[2] + np[3], 0);
        check("idle_level", int'(btn_level), 0);

        // ---------------- clean press / release on ch0 ----------------
        btn_in[0] = 1'b0;
        watch(50, 0);
        check("clean_press_tick", fp[0], 7);
        check("clean_press_count", np[0], 1);
        check("clean_press_no_rel", nr[0], 0);
        check("clean_level_held", int'(btn_level[0]), 1);
        check("clean_other_quiet", np[1] + np[2] + np[3], 0);
        btn_in[0] = 1'b1;
        watch(20, 0);
        check("clean_rel_tick", fr[0], 7);
        check("clean_rel_count", nr[0], 1);
        check("clean_rel_no_press", np[0], 0);
        check("clean_level_rel", int'(btn_level[0]), 0);

        // ---------------- glitch rejection on ch1 ----------------
        btn_in[1] = 1'b0;
        watch(3, 1);
        np_acc = np[1]; nr_acc = nr[1];
        btn_in[1] = 1'b1;
        watch(20, 1);
        check("glitch_no_press", np_acc + np[1], 0);
        check("glitch_no_rel", nr_acc + nr[1], 0);
        check("glitch_level", int'(btn_level[1]), 0);

        // ---------------- bounce during release on ch0 ----------------
        btn_in[0] = 1'b0;
        watch(20, 0);
        check("bounce_press_count", np[0], 1);
        btn_in[0] = 1'b1;
        watch(3, 0);
        np_acc = np[0]; nr_acc = nr[0];
        btn_in[0] = 1'b0;
        watch(2, 0);
        np_acc += np[0]; nr_acc += nr[0];
        btn_in[0] = 1'b1;
        watch(20, 0);
        check("bounce_no_early_rel", nr_acc, 0);
        check("bounce_rel_tick", fr[0], 7);
        check("bounce_rel_count", nr[0], 1);
        check("bounce_no_press", np_acc + np[0], 0);

        // ---------------- auto-repeat on ch2 ----------------
        repeat_en[2] = 1'b1;
        btn_in[2]    = 1'b0;
        watch(46, 2);
        check("rep_count", pt_n, 7);
        for (int k = 0; k < 7; k++)
            check($sformatf("rep_tick%0d", k), pt[k], exp_rep[k]);
        check("rep_both", both, 0);
        repeat_en[2] = 1'b0;
        watch(30, 2);
        check("rep_disabled", np[2], 0);
        repeat_en[2] = 1'b1;
        watch(12, 2);
        check("rep_reenable_count", np[2], 1);
        check("rep_reenable_tick", fp[2], 10);
        repeat_en[2] = 1'b0;
        btn_in[2]    = 1'b1;
        watch(20, 2);
        check("rep_rel_tick", fr[2], 7);
        check("rep_rel_no_press", np[2], 0);

        // ---------------- simultaneous press on all channels ----------------
        btn_in = '0;
        watch(7, 0);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("sim_press_tick%0d", c), fp[c], 7);
            check($sformatf("sim_press_cnt%0d", c), np[c], 1);
        end
        check("sim_press_vector", int'(press_pulse), 15);
        btn_in = '1;
        watch(20, 0);
        for (int c = 0; c < CH; c++)
            check($sformatf("sim_rel_tick%0d", c), fr[c], 7);

        // ---------------- reset mid-operation ----------------
        btn_in[3] = 1'b0;
        watch(10, 3);
        check("mid_ch3_held", int'(btn_level[3]), 1);
        btn_in[0] = 1'b0;
        watch(4, 0);
        check("mid_ch0_not_yet", np[0], 0);
        rst = 1'b0;
        step();
        check("mid_rst_press", int'(press_pulse), 0);
        check("mid_rst_release", int'(release_pulse), 0);
        check("mid_rst_level", int'(btn_level), 0);
        step();
        check("mid_rst_level2", int'(btn_level), 0);
        rst = 1'b1;
        watch(20, 0);
        check("mid_after_ch0_tick", fp[0], 7);
        check("mid_after_ch3_tick", fp[3], 7);
        check("mid_after_ch0_cnt", np[0], 1);
        check("mid_after_no_rel", nr[0] + nr[1] + nr[2] + nr[3], 0);
        btn_in = '1;
        watch(20, 0);
        check("mid_final_rel0", fr[0], 7);
        check("mid_final_rel3", fr[3], 7);
        check("mid_final_both", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
